// File: rtl/mac_array.sv
// mac_array: LANES parallel multiply-accumulates over TAPS coefficients read from a packed ROM; optional MAC_SATURATE_EN.
// Latency: done pulses one cycle after the final tap is consumed, so an unstalled run takes TAPS+1 cycles.
// Backpressure: x_valid=0 stalls the run in place; x_shift marks each consumed sample.
module mac_array #(
  parameter int LANES         = 4,
  parameter int DATA_W        = 9,
  parameter int COEF_W        = 7,
  parameter int COEF_PER_WORD = 2,
  parameter int TAPS          = 32,
  parameter int ACC_W         = 18,
  parameter int SIGNED        = 0,
  localparam int AW = (TAPS / COEF_PER_WORD > 1) ? $clog2(TAPS / COEF_PER_WORD) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [LANES*DATA_W-1:0]           x_data,
  input  logic                              x_valid,
  output logic                              x_shift,
  output logic [AW-1:0]                     rom_addr,
  input  logic [COEF_PER_WORD*COEF_W-1:0]   rom_data,
  output logic [LANES*ACC_W-1:0]            acc,
  output logic                              busy,
  output logic                              done,
  output logic [LANES-1:0]                  ovf
);

  localparam int PW = COEF_W + DATA_W;
  localparam int TW = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tap_q, tap_d;
  logic [ACC_W-1:0]  acc_q [LANES];
  logic [ACC_W-1:0]  acc_d [LANES];
  logic [ACC_W-1:0]  lane_next [LANES];
  logic [COEF_W-1:0] coef;
`ifdef MAC_SATURATE_EN
  logic [LANES-1:0]  lane_ovr;
  logic [LANES-1:0]  ovf_q, ovf_d;
`endif

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign x_shift  = busy && x_valid;
  assign rom_addr = AW'(int'(tap_q) / COEF_PER_WORD);
  assign coef     = rom_data[(int'(tap_q) % COEF_PER_WORD) * COEF_W +: COEF_W];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] x_i;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  sum_w;

    assign x_i = x_data[i*DATA_W +: DATA_W];

    if (SIGNED != 0) begin : g_sgn
      logic signed [PW-1:0] prod_s;
      assign prod_s   = PW'($signed(coef)) * PW'($signed(x_i));
      assign prod_ext = ACC_W'(prod_s);
    end else begin : g_uns
      logic [PW-1:0] prod_u;
      assign prod_u   = PW'(coef) * PW'(x_i);
      assign prod_ext = ACC_W'(prod_u);
    end

    assign sum_w = acc_q[i] + prod_ext;

`ifdef MAC_SATURATE_EN
    // Overflow is judged per accumulate, so clamping stays exact across the run.
    logic [ACC_W-1:0] sat_v;
    if (SIGNED != 0) begin : g_sat_s
      assign lane_ovr[i] = (acc_q[i][ACC_W-1] == prod_ext[ACC_W-1]) &&
                           (sum_w[ACC_W-1] != acc_q[i][ACC_W-1]);
      assign sat_v = acc_q[i][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin : g_sat_u
      assign lane_ovr[i] = (sum_w < acc_q[i]);
      assign sat_v       = '1;
    end
    assign lane_next[i] = lane_ovr[i] ? sat_v : sum_w;
`else
    assign lane_next[i] = sum_w;
`endif

    assign acc[i*ACC_W +: ACC_W] = acc_q[i];
  end

`ifdef MAC_SATURATE_EN
  assign ovf = ovf_q;
`else
  assign ovf = '0;
`endif

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    for (int l = 0; l < LANES; l++) acc_d[l] = acc_q[l];
`ifdef MAC_SATURATE_EN
    ovf_d = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          tap_d   = '0;
          for (int l = 0; l < LANES; l++) acc_d[l] = '0;
`ifdef MAC_SATURATE_EN
          ovf_d = '0;
`endif
        end
      end
      RUN: begin
        if (x_valid) begin
          for (int l = 0; l < LANES; l++) acc_d[l] = lane_next[l];
`ifdef MAC_SATURATE_EN
          ovf_d = ovf_q | lane_ovr;
`endif
          // Counter parks on the last tap instead of wrapping.
          if (tap_q == TW'(TAPS - 1)) state_d = DONE;
          else                        tap_d   = tap_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
`ifdef MAC_SATURATE_EN
      ovf_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
`ifdef MAC_SATURATE_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: directed and randomized runs of mac_array against a tap-by-tap arithmetic model.
module tb_mac_array;

  localparam int LANES  = 4;
  localparam int DATA_W = 9;
  localparam int COEF_W = 7;
  localparam int CPW    = 2;
  localparam int TAPS   = 32;
  localparam int ACC_W  = 18;
  localparam int AW     = $clog2(TAPS / CPW);

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [LANES*DATA_W-1:0]   x_data;
  logic                      x_valid;
  logic                      x_shift;
  logic [AW-1:0]             rom_addr;
  logic [CPW*COEF_W-1:0]     rom_data;
  logic [LANES*ACC_W-1:0]    acc;
  logic                      busy;
  logic                      done;
  logic [LANES-1:0]          ovf;

  logic [COEF_W-1:0] coef_mem [TAPS];
  logic [DATA_W-1:0] xs [TAPS][LANES];

  int n_chk  = 0;
  int n_pass = 0;

  int g_done_cyc, g_shifts, g_busy, g_addr_err;
  bit g_done;

  mac_array dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x_data   (x_data),
    .x_valid  (x_valid),
    .x_shift  (x_shift),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .acc      (acc),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always_comb begin
    rom_data = '0;
    for (int j = 0; j < CPW; j++)
      rom_data[j*COEF_W +: COEF_W] = coef_mem[int'(rom_addr)*CPW + j];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic fill(input int mode);
    for (int t = 0; t < TAPS; t++) begin
      case (mode)
        0:       coef_mem[t] = COEF_W'(1);
        1:       coef_mem[t] = '1;
        default: coef_mem[t] = COEF_W'($urandom);
      endcase
      for (int l = 0; l < LANES; l++)
        xs[t][l] = (mode == 0) ? DATA_W'(l + 1) : (mode == 1) ? '1 : DATA_W'($urandom);
    end
  endtask

  // Sum of products per lane, then clamped (saturating build) or reduced mod 2^ACC_W.
  task automatic model(output logic [LANES*ACC_W-1:0] eacc, output logic [LANES-1:0] eovf);
    longint maxv = (longint'(1) << ACC_W) - 1;
    eacc = '0;
    eovf = '0;
    for (int l = 0; l < LANES; l++) begin
      longint a = 0;
      bit o = 0;
      for (int t = 0; t < TAPS; t++) begin
        a += longint'(coef_mem[t]) * longint'(xs[t][l]);
`ifdef MAC_SATURATE_EN
        if (a > maxv) begin a = maxv; o = 1; end
`endif
      end
      a = a & maxv;
      eacc[l*ACC_W +: ACC_W] = a[ACC_W-1:0];
      eovf[l] = o;
    end
  endtask

  // vmode: 0 always valid, 1 valid on even cycles, 2 random. abort_at>=0 returns after that many consumptions.
  task automatic do_run(input int vmode, input bit spam, input int abort_at);
    int k = 0;
    g_done = 0; g_done_cyc = 0; g_shifts = 0; g_busy = 0; g_addr_err = 0;
    @(negedge clk);
    start   = 1'b1;
    x_valid = 1'b1;
    for (int l = 0; l < LANES; l++) x_data[l*DATA_W +: DATA_W] = xs[0][l];
    @(posedge clk);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = spam;
      case (vmode)
        0:       x_valid = 1'b1;
        1:       x_valid = ~cyc[0];
        default: x_valid = ($urandom_range(0, 3) != 0);
      endcase
      for (int l = 0; l < LANES; l++)
        x_data[l*DATA_W +: DATA_W] = (k < TAPS) ? xs[k][l] : DATA_W'($urandom);
      if (abort_at >= 0 && k == abort_at) break;
      #1;
      if (done) begin g_done = 1; g_done_cyc = cyc; break; end
      if (busy) g_busy++;
      if (x_shift) begin
        if (rom_addr !== AW'(k / CPW)) g_addr_err++;
        g_shifts++;
        k++;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int exp_cyc, input int exp_busy);
    logic [LANES*ACC_W-1:0] eacc;
    logic [LANES-1:0]       eovf;
    model(eacc, eovf);
    check({tag, "_done_seen"}, 128'(g_done), 128'(1));
    if (exp_cyc > 0)  check({tag, "_done_cycle"}, 128'(g_done_cyc), 128'(exp_cyc));
    if (exp_busy > 0) check({tag, "_run_cycles"}, 128'(g_busy), 128'(exp_busy));
    check({tag, "_shifts"},   128'(g_shifts),   128'(TAPS));
    check({tag, "_rom_addr"}, 128'(g_addr_err), 128'(0));
    check({tag, "_acc"},      128'(acc),        128'(eacc));
    check({tag, "_ovf"},      128'(ovf),        128'(eovf));
  endtask

  // Results must stay frozen while idle inputs wiggle.
  task automatic hold_check(input string tag);
    logic [LANES*ACC_W-1:0] snap = acc;
    logic [LANES-1:0]       osnap = ovf;
    int busy_seen = 0;
    int done_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      x_valid = 1'(($urandom) & 1);
      x_data  = {LANES{DATA_W'($urandom)}};
      #1;
      if (busy || x_shift) busy_seen++;
      if (done) done_seen++;
    end
    check({tag, "_hold_acc"},  128'(acc),       128'(snap));
    check({tag, "_hold_ovf"},  128'(ovf),       128'(osnap));
    check({tag, "_hold_idle"}, 128'(busy_seen), 128'(0));
    check({tag, "_done_once"}, 128'(done_seen), 128'(0));
  endtask

  initial begin
    logic [LANES*ACC_W-1:0] lit;
    longint wrapv;
    int stray_done, stray_busy;

    rst = 1'b1; start = 1'b0; x_valid = 1'b0; x_data = '0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    x_valid = 1'b1;
    #1;
    check("rst_busy",    128'(busy),     128'(0));
    check("rst_done",    128'(done),     128'(0));
    check("rst_x_shift", 128'(x_shift),  128'(0));
    check("rst_rom",     128'(rom_addr), 128'(0));
    check("rst_acc",     128'(acc),      128'(0));
    check("rst_ovf",     128'(ovf),      128'(0));

    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("idle_no_shift", 128'(x_shift), 128'(0));
    check("idle_no_busy",  128'(busy),    128'(0));

    // Baseline: unit coefficients, lane i sees constant i+1.
    fill(0);
    do_run(0, 0, -1);
    check_run("base", TAPS + 1, TAPS);
    lit = {18'd128, 18'd96, 18'd64, 18'd32};
    check("base_literal", 128'(acc), 128'(lit));
    hold_check("base");

    // Half-rate valid: two cycles per tap.
    do_run(1, 0, -1);
    check_run("toggle", 2 * TAPS + 1, 2 * TAPS);
    check("toggle_literal", 128'(acc), 128'(lit));

    // Largest operands on every tap.
    fill(1);
    do_run(0, 0, -1);
    check_run("maxval", TAPS + 1, TAPS);
    wrapv = (longint'(TAPS) * 127 * 511) % (longint'(1) << ACC_W);
`ifdef MAC_SATURATE_EN
    check("maxval_lit_acc", 128'(acc), 128'({LANES{18'h3FFFF}}));
    check("maxval_lit_ovf", 128'(ovf), 128'(4'hF));
`else
    check("maxval_lit_acc", 128'(acc), 128'({LANES{wrapv[ACC_W-1:0]}}));
    check("maxval_lit_ovf", 128'(ovf), 128'(0));
`endif

    // Randomized coefficients, samples and valid gaps.
    for (int r = 0; r < 3; r++) begin
      fill(2);
      do_run(2, 0, -1);
      check_run($sformatf("rand%0d", r), 0, 0);
    end

    // start held high throughout RUN and DONE must not restart or clear.
    fill(2);
    do_run(2, 1, -1);
    check_run("spam", 0, 0);
    hold_check("spam");

    // Reset in the middle of a run.
    fill(2);
    do_run(0, 0, 10);
    rst = 1'b1;
    #1;
    check("abort_acc",  128'(acc),      128'(0));
    check("abort_busy", 128'(busy),     128'(0));
    check("abort_rom",  128'(rom_addr), 128'(0));
    check("abort_shift",128'(x_shift),  128'(0));
    check("abort_ovf",  128'(ovf),      128'(0));
    @(negedge clk);
    rst = 1'b0;
    stray_done = 0; stray_busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      x_valid = 1'b1;
      #1;
      if (done) stray_done++;
      if (busy) stray_busy++;
    end
    check("abort_no_done", 128'(stray_done), 128'(0));
    check("abort_no_run",  128'(stray_busy), 128'(0));
    do_run(0, 0, -1);
    check_run("after_abort", TAPS + 1, TAPS);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
